// File: rtl/fp32_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp32_arb_pkg
// Description : Shared types and constants for the FP32 multiplier arbiter:
//               result status flags, FSM state encoding, flag bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
package fp32_arb_pkg;

    // Bit positions of the status flags inside the packed 3-bit flag word
    localparam int FLAG_OVERFLOW  = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INVALID   = 2;

    typedef struct packed {
        logic invalid;
        logic underflow;
        logic overflow;
    } flags_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp32_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fp32_arb_tag_fifo
// Description : Synchronous tag FIFO recording which requester issued each
//               in-flight multiply. DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_arb_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int                 c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]      c_depth = (c_aw+1)'(DEPTH);
    localparam logic [c_aw:0]      c_one   = (c_aw+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Overflowing pushes and underflowing pops are ignored
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign full_o  = (r_count == c_depth);
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd_ptr];

    // Storage array: written on push, no reset needed
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp32_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp32_mul_arbiter
// Description : Round-robin sharing of one pipelined FP32 multiplier between
//               NUM_REQ requesters, with in-order result routing via a tag
//               FIFO, drain/quiesce control and a sticky orphan-result error.
//               Optional macro FP32_ARB_STICKY_EN adds per-requester sticky
//               flag accumulators (sticky_o / sticky_clr_i).
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_mul_arbiter
    import fp32_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*32-1:0]  req_a_i,
    input  logic [NUM_REQ*32-1:0]  req_b_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     resp_valid_o,
    output logic [31:0]            resp_result_o,
    output logic [2:0]             resp_flags_o,
    output logic                   mul_valid_o,
    output logic [31:0]            mul_a_o,
    output logic [31:0]            mul_b_o,
    input  logic [31:0]            mul_result_i,
    input  logic                   mul_done_i,
    input  logic                   mul_overflow_i,
    input  logic                   mul_underflow_i,
    input  logic                   mul_invalid_i,
    input  logic                   drain_i,
    output logic                   idle_o,
`ifdef FP32_ARB_STICKY_EN
    output logic [NUM_REQ*3-1:0]   sticky_o,
    input  logic [NUM_REQ-1:0]     sticky_clr_i,
`endif
    output logic                   err_o
);

    localparam int                c_iw     = $clog2(NUM_REQ);
    localparam int                c_cw     = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [c_iw-1:0]   c_last   = c_iw'(NUM_REQ - 1);
    localparam logic [c_iw:0]     c_nreq   = (c_iw+1)'(NUM_REQ);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_iw-1:0]    r_ptr;
    logic [c_iw:0]      w_rr_sum;
    logic [c_iw-1:0]    w_rr_idx;
    logic               w_gnt_found;
    logic [c_iw-1:0]    w_gnt_idx;
    logic [NUM_REQ-1:0] w_gnt_onehot;
    logic               w_gnt_en;
    logic               w_grant;
    logic               w_pop;
    logic [c_iw-1:0]    w_tag;
    logic               w_full;
    logic               w_empty;
    logic [c_cw-1:0]    w_count;
    logic [2:0]         w_flag_vec;

    logic               r_mul_valid;
    logic [31:0]        r_mul_a;
    logic [31:0]        r_mul_b;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [31:0]        r_resp_result;
    flags_t             r_resp_flags;
    logic               r_err;

    // Round-robin search starting at r_ptr; first valid requester wins
    always_comb begin
        w_gnt_found  = 1'b0;
        w_gnt_idx    = '0;
        w_gnt_onehot = '0;
        w_rr_sum     = '0;
        w_rr_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_rr_sum = {1'b0, r_ptr} + (c_iw+1)'(k);
            if (w_rr_sum >= c_nreq) begin
                w_rr_sum = w_rr_sum - c_nreq;
            end
            w_rr_idx = w_rr_sum[c_iw-1:0];
            if (!w_gnt_found && req_valid_i[w_rr_idx]) begin
                w_gnt_found  = 1'b1;
                w_gnt_idx    = w_rr_idx;
                w_gnt_onehot = NUM_REQ'(1) << w_rr_idx;
            end
        end
    end

    // Grants stop as soon as drain_i rises and stay off while draining; a
    // full FIFO blocks grants even if a pop happens in the same cycle.
    assign w_gnt_en    = (r_state != DRAIN) && !drain_i && !w_full;
    assign w_grant     = w_gnt_en && w_gnt_found;
    assign req_ready_o = w_gnt_en ? w_gnt_onehot : '0;

    // Results with no recorded issuer are dropped and flagged via err_o
    assign w_pop = mul_done_i && !w_empty;

    assign w_flag_vec[FLAG_INVALID]   = mul_invalid_i;
    assign w_flag_vec[FLAG_UNDERFLOW] = mul_underflow_i;
    assign w_flag_vec[FLAG_OVERFLOW]  = mul_overflow_i;

    fp32_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (c_iw)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_grant),
        .data_i  (w_gnt_idx),
        .pop_i   (w_pop),
        .data_o  (w_tag),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: drain request overrides normal activity
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (drain_i)      w_state_nxt = DRAIN;
                else if (w_grant) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (drain_i)                           w_state_nxt = DRAIN;
                else if (w_count == '0 && !w_grant)    w_state_nxt = IDLE;
            end
            DRAIN: begin
                if (w_count == '0 && !drain_i)         w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Issue path: round-robin pointer and registered multiplier operands
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr       <= '0;
            r_mul_valid <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            r_mul_valid <= w_grant;
            if (w_grant) begin
                r_ptr   <= (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;
                r_mul_a <= req_a_i[w_gnt_idx*32 +: 32];
                r_mul_b <= req_b_i[w_gnt_idx*32 +: 32];
            end
        end
    end

    // Return path: route each result to its issuer; data holds between strobes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp_valid  <= '0;
            r_resp_result <= '0;
            r_resp_flags  <= '0;
            r_err         <= 1'b0;
        end else begin
            r_resp_valid <= '0;
            if (w_pop) begin
                r_resp_valid  <= NUM_REQ'(1) << w_tag;
                r_resp_result <= mul_result_i;
                r_resp_flags  <= flags_t'(w_flag_vec);
            end
            if (mul_done_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef FP32_ARB_STICKY_EN
    logic [NUM_REQ*3-1:0] r_sticky;

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_sticky
            // Accumulate returned flags per requester; clear beats a response
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_sticky[g*3 +: 3] <= '0;
                end else if (sticky_clr_i[g]) begin
                    r_sticky[g*3 +: 3] <= '0;
                end else if (r_resp_valid[g]) begin
                    r_sticky[g*3 +: 3] <= r_sticky[g*3 +: 3] | r_resp_flags;
                end
            end
        end
    endgenerate

    assign sticky_o = r_sticky;
`endif

    assign mul_valid_o   = r_mul_valid;
    assign mul_a_o       = r_mul_a;
    assign mul_b_o       = r_mul_b;
    assign resp_valid_o  = r_resp_valid;
    assign resp_result_o = r_resp_result;
    assign resp_flags_o  = r_resp_flags;
    assign err_o         = r_err;
    assign idle_o        = (r_state == IDLE);

endmodule
`default_nettype wire

// File: doc/fp32_mul_arbiter.md
# fp32_mul_arbiter

Shares one pipelined FP32 multiplier (`fp32Multiplier`) between NUM_REQ requesters. Each cycle a round-robin grant issues at most one operand pair into the multiplier. A tag FIFO records which requester issued each in-flight operation, and each result and its status flags are routed back to that requester. The block sits between the compute clients and the multiplier instance and also provides a drain/quiesce control.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- MAX_OUTSTANDING, 8: in-flight operation limit and tag FIFO depth; power of two, at least the multiplier latency + 1.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester operation request.
- req_a_i, req_b_i  in  NUM_REQ×32  per-requester FP32 operands.
- req_ready_o  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid_i[i] and req_ready_o[i] are both high.
- resp_valid_o  out  NUM_REQ  one-hot, one-cycle result strobe; no backpressure.
- resp_result_o  out  32  result, shared by all requesters.
- resp_flags_o  out  3  {invalid, underflow, overflow}, shared.
- mul_valid_o, mul_a_o, mul_b_o  out  1/32/32  drive the multiplier inputs.
- mul_result_i, mul_done_i, mul_overflow_i, mul_underflow_i, mul_invalid_i  in  from the multiplier.
- drain_i  in  1  level: stop granting and let in-flight operations complete.
- idle_o  out  1  high when the FSM is in IDLE.
- err_o  out  1  sticky: a mul_done_i arrived with the tag FIFO empty.

## Operation
- FSM states and transitions:
  - IDLE to BUSY on a grant.
  - BUSY to IDLE when outstanding reaches 0 with no grant in that cycle.
  - IDLE or BUSY to DRAIN when drain_i is high.
  - DRAIN to IDLE when outstanding is 0 and drain_i is low.
  - While drain_i stays high, the FSM holds in DRAIN even at outstanding 0; idle_o stays 0 until exit.
- Grant:
  - Allowed only outside DRAIN and only while outstanding < MAX_OUTSTANDING.
  - req_ready_o is combinational from req_valid_i, the round-robin pointer and the outstanding count.
  - When the FIFO is full, no grant is made even if a pop occurs in the same cycle (no bypass).
- Round robin: search starts at ptr; after a grant to i, ptr becomes (i+1) mod NUM_REQ; ptr is unchanged when there is no grant.
- Issue: a grant registers the operands into mul_a_o/mul_b_o, sets mul_valid_o for one cycle, and pushes the granted index into the tag FIFO.
- Return:
  - mul_done_i pops the tag.
  - Next cycle: resp_valid_o[tag]=1, resp_result_o=mul_result_i, resp_flags_o = {mul_invalid_i, mul_underflow_i, mul_overflow_i}.
  - The multiplier is in-order, so FIFO order equals result order.
- Outstanding counter: width $clog2(MAX_OUTSTANDING)+1; +1 on push, -1 on pop; unchanged on a simultaneous push and pop.
- mul_done_i with the FIFO empty: no pop, no resp_valid_o; err_o is set and held until reset.
- Reset values: all outputs 0 except idle_o=1; ptr=0; count=0; FIFO empty; FSM in IDLE.
- Reset mid-operation discards all in-flight tags. The integrator resets the multiplier in the same cycle (its rstn_i is driven from ~rst_i).

## Timing
- Handshake at cycle t gives mul_valid_o at t+1.
- mul_done_i at cycle u gives resp_valid_o at u+1.
- End-to-end latency is L_mul+2 cycles, where L_mul is the multiplier latency from valid_i to done_o.
- Sustained throughput is 1 operation/cycle across all requesters while outstanding < MAX_OUTSTANDING.
- A requester's operand signals must be stable while its req_valid_i is high and not yet granted.
- resp_result_o and resp_flags_o hold their last value when no resp_valid_o is asserted.

## Configuration
- FP32_ARB_STICKY_EN, when defined:
  - Adds ports sticky_o (NUM_REQ×3, out) and sticky_clr_i (NUM_REQ, in).
  - Each returned response ORs its flags into sticky_o[tag].
  - sticky_clr_i[i] zeroes entry i; on the same cycle as a response to i, the clear wins, so the response's flags are lost.
  - Reset value of sticky_o is 0.
- When undefined, these ports and registers do not exist, and there is no other change in behaviour.

## Structure
- Package fp32_arb_pkg holds:
  - flags_t, a packed {invalid, underflow, overflow};
  - the FSM state enum {IDLE, BUSY, DRAIN};
  - the FLAG_* bit-index constants.
- Sub-module fp32_arb_tag_fifo: synchronous FIFO with parameters DEPTH and WIDTH=$clog2(NUM_REQ), push/pop/full/empty/count, and the same reset as this block.

## Test plan
- Single request: requester 2 issues A=0x40000000, B=0x40400000 → mul_valid_o 1 cycle later; resp_valid_o=4'b0100 with result 0x40C00000 and flags 0 at L_mul+2.
- All 4 requesters held valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; every response arrives at its issuer.
- MAX_OUTSTANDING=4 and a 6-cycle multiplier stub → grants stop at 4 outstanding and resume only in the cycle after the first pop.
- drain_i asserted with 3 operations in flight → no new grants, 3 responses return, then idle_o=1 after drain_i falls.
- mul_done_i injected with the FIFO empty → err_o=1 and stays 1; no resp_valid_o.
- FP32_ARB_STICKY_EN defined: requester 1 computes 0x7F800000×0x00000000 → sticky_o[1]=3'b100; sticky_clr_i[1] pulse → 0.
